// File: rtl/rf_operand_fetch_pkg.sv
// Shared constants for the operand-fetch front end.
// Default widths and register-file geometry.
package rf_operand_fetch_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   // Operands travelling from fetch to execute.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [ADDR_W-1:0] rd;
      logic              wen;
   } fetch_ex_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// Writeback clears are forwarded into the busy lookups.
module rf_scoreboard
   import rf_operand_fetch_pkg::*;
#(
   parameter int unsigned addr_w = ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              set_i,
   input  logic [addr_w-1:0] set_addr_i,
   input  logic              clr_i,
   input  logic [addr_w-1:0] clr_addr_i,
   input  logic [addr_w-1:0] chk_a_i,
   input  logic [addr_w-1:0] chk_b_i,
   input  logic [addr_w-1:0] chk_d_i,
   output logic              busy_a_o,
   output logic              busy_b_o,
   output logic              busy_d_o
);

   localparam int unsigned N = 2 ** addr_w;

   logic [N-1:0] pend_q;
   logic [N-1:0] pend_d;

   // Next pending vector: clear first, set last so a set wins.
   always_comb begin
      pend_d = pend_q;
      if (clr_i) begin
         pend_d[clr_addr_i] = 1'b0;
      end
      if (set_i) begin
         pend_d[set_addr_i] = 1'b1;
      end
   end

   // Pending-bit register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // A register is busy unless its writeback lands this cycle.
   always_comb begin
      busy_a_o = pend_q[chk_a_i] &&
                 !(clr_i && (clr_addr_i == chk_a_i));
      busy_b_o = pend_q[chk_b_i] &&
                 !(clr_i && (clr_addr_i == chk_b_i));
      busy_d_o = pend_q[chk_d_i] &&
                 !(clr_i && (clr_addr_i == chk_d_i));
   end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch / writeback front end of the regfile.
// Bypasses writeback data and stalls on RAW/WAW hazards.
module rf_operand_fetch
   import rf_operand_fetch_pkg::*;
#(
   parameter int unsigned data_w = DATA_W,
   parameter int unsigned addr_w = ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_VALID,
   output logic              I_READY,
   input  logic [addr_w-1:0] I_RS1,
   input  logic [addr_w-1:0] I_RS2,
   input  logic [addr_w-1:0] I_RD,
   input  logic              I_WEN,
   output logic [addr_w-1:0] RF_RA,
   output logic [addr_w-1:0] RF_RB,
   input  logic [data_w-1:0] RF_DA,
   input  logic [data_w-1:0] RF_DB,
   output logic              RF_WE,
   output logic [addr_w-1:0] RF_RW,
   output logic [data_w-1:0] RF_DW,
   input  logic              WB_VALID,
   input  logic [addr_w-1:0] WB_RD,
   input  logic [data_w-1:0] WB_DATA,
   output logic              O_VALID,
   input  logic              O_READY,
   output logic [data_w-1:0] O_A,
   output logic [data_w-1:0] O_B,
   output logic [addr_w-1:0] O_RD,
   output logic              O_WEN
);

   logic              busy_a;
   logic              busy_b;
   logic              busy_d;
   logic              stall;
   logic              out_free;
   logic              accept;
   logic [data_w-1:0] opa;
   logic [data_w-1:0] opb;

   logic              valid_q, valid_d;
   logic [data_w-1:0] a_q, a_d;
   logic [data_w-1:0] b_q, b_d;
   logic [addr_w-1:0] rd_q, rd_d;
   logic              wen_q, wen_d;

   // Regfile ports are straight passthrough.
   assign RF_RA = I_RS1;
   assign RF_RB = I_RS2;
   assign RF_WE = WB_VALID;
   assign RF_RW = WB_RD;
   assign RF_DW = WB_DATA;

   rf_scoreboard #(
      .addr_w (addr_w)
   ) u_sb (
      .clk_i      (CLK),
      .rst_i      (RST),
      .set_i      (accept && I_WEN),
      .set_addr_i (I_RD),
      .clr_i      (WB_VALID),
      .clr_addr_i (WB_RD),
      .chk_a_i    (I_RS1),
      .chk_b_i    (I_RS2),
      .chk_d_i    (I_RD),
      .busy_a_o   (busy_a),
      .busy_b_o   (busy_b),
      .busy_d_o   (busy_d)
   );

   // Operand select with same-cycle writeback bypass.
   always_comb begin
      opa = RF_DA;
      opb = RF_DB;
      if (WB_VALID && (WB_RD == I_RS1)) begin
         opa = WB_DATA;
      end
      if (WB_VALID && (WB_RD == I_RS2)) begin
         opb = WB_DATA;
      end
   end

   // Issue handshake: ready never looks at I_VALID.
   always_comb begin
      stall    = busy_a || busy_b || (I_WEN && busy_d);
      out_free = !valid_q || O_READY;
      I_READY  = out_free && !stall;
      accept   = I_VALID && I_READY;
   end

   // Output stage next state: load, drain or hold.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      rd_d    = rd_q;
      wen_d   = wen_q;
      if (accept) begin
         valid_d = 1'b1;
         a_d     = opa;
         b_d     = opb;
         rd_d    = I_RD;
         wen_d   = I_WEN;
      end else if (O_READY) begin
         valid_d = 1'b0;
      end
   end

   // Output stage registers; reset drops any in-flight op.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
      end
   end

   assign O_VALID = valid_q;
   assign O_A     = a_q;
   assign O_B     = b_q;
   assign O_RD    = rd_q;
   assign O_WEN   = wen_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: directed steps then random traffic.
// A regfile and an abstract model live in the bench.
module tb_rf_operand_fetch;

   logic        CLK = 1'b0;
   logic        RST;
   logic        I_VALID;
   logic        I_READY;
   logic [4:0]  I_RS1, I_RS2, I_RD;
   logic        I_WEN;
   logic [4:0]  RF_RA, RF_RB;
   logic [31:0] RF_DA, RF_DB;
   logic        RF_WE;
   logic [4:0]  RF_RW;
   logic [31:0] RF_DW;
   logic        WB_VALID;
   logic [4:0]  WB_RD;
   logic [31:0] WB_DATA;
   logic        O_VALID;
   logic        O_READY;
   logic [31:0] O_A, O_B;
   logic [4:0]  O_RD;
   logic        O_WEN;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   rf_operand_fetch dut (
      .CLK(CLK), .RST(RST),
      .I_VALID(I_VALID), .I_READY(I_READY),
      .I_RS1(I_RS1), .I_RS2(I_RS2), .I_RD(I_RD), .I_WEN(I_WEN),
      .RF_RA(RF_RA), .RF_RB(RF_RB), .RF_DA(RF_DA), .RF_DB(RF_DB),
      .RF_WE(RF_WE), .RF_RW(RF_RW), .RF_DW(RF_DW),
      .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
      .O_VALID(O_VALID), .O_READY(O_READY),
      .O_A(O_A), .O_B(O_B), .O_RD(O_RD), .O_WEN(O_WEN)
   );

   // Environment regfile: combinational read, posedge write.
   logic [31:0] rf [32];
   assign RF_DA = rf[RF_RA];
   assign RF_DB = rf[RF_RB];
   always @(posedge CLK) if (RF_WE) rf[RF_RW] <= RF_DW;

   // Reference model state.
   logic [31:0] m_rf [32];
   bit          m_pend [32];
   bit          m_known = 0;
   logic        m_ov;
   logic [31:0] m_oa, m_ob;
   logic [4:0]  m_ord;
   logic        m_owen;
   bit          p_acc;
   logic [31:0] p_a, p_b;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit busy(input logic [4:0] r);
      return m_pend[r] && !(WB_VALID && WB_RD == r);
   endfunction

   // Before the edge: check combinational outputs, plan the step.
   task automatic settle();
      bit rdy;
      #2;
      chk("rf_ra", 32'(RF_RA), 32'(I_RS1));
      chk("rf_rb", 32'(RF_RB), 32'(I_RS2));
      chk("rf_we", 32'(RF_WE), 32'(WB_VALID));
      if (WB_VALID) begin
         chk("rf_rw", 32'(RF_RW), 32'(WB_RD));
         chk("rf_dw", RF_DW, WB_DATA);
      end
      p_acc = 0;
      if (m_known) begin
         rdy = (!m_ov || O_READY) &&
               !(busy(I_RS1) || busy(I_RS2) || (I_WEN && busy(I_RD)));
         chk("i_ready", 32'(I_READY), 32'(rdy));
         p_acc = I_VALID && rdy;
      end
      p_a = (WB_VALID && WB_RD == I_RS1) ? WB_DATA : m_rf[I_RS1];
      p_b = (WB_VALID && WB_RD == I_RS2) ? WB_DATA : m_rf[I_RS2];
   endtask

   // Across the edge: advance the model, check the registered outputs.
   task automatic edge_step();
      @(posedge CLK);
      #1;
      if (RST) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 0;
         m_ov = 0; m_oa = 0; m_ob = 0; m_ord = 0; m_owen = 0;
         m_known = 1;
      end else if (m_known) begin
         if (WB_VALID) m_pend[WB_RD] = 0;
         if (p_acc && I_WEN) m_pend[I_RD] = 1;
         if (p_acc) begin
            m_ov = 1; m_oa = p_a; m_ob = p_b;
            m_ord = I_RD; m_owen = I_WEN;
         end else if (O_READY) begin
            m_ov = 0;
         end
      end
      if (WB_VALID) m_rf[WB_RD] = WB_DATA;
      if (m_known) begin
         chk("o_valid", 32'(O_VALID), 32'(m_ov));
         chk("o_a", O_A, m_oa);
         chk("o_b", O_B, m_ob);
         chk("o_rd", 32'(O_RD), 32'(m_ord));
         chk("o_wen", 32'(O_WEN), 32'(m_owen));
      end
   endtask

   task automatic cycle();
      settle();
      edge_step();
   endtask

   task automatic issue(input logic v, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d,
                        input logic w);
      I_VALID = v; I_RS1 = a; I_RS2 = b; I_RD = d; I_WEN = w;
   endtask

   task automatic wb(input logic v, input logic [4:0] r,
                     input logic [31:0] d);
      WB_VALID = v; WB_RD = r; WB_DATA = d;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf[i]   = 32'h1000 + i;
         m_rf[i] = 32'h1000 + i;
      end
      RST = 1; O_READY = 1;
      issue(1, 1, 2, 3, 1);
      wb(0, 0, 0);

      // Reset held two cycles with a request pending.
      cycle();
      cycle();
      chk("rst_ovalid", 32'(O_VALID), 32'h0);
      chk("rst_oa", O_A, 32'h0);
      RST = 0;
      issue(0, 1, 2, 3, 1);
      settle();
      chk("rst_iready", 32'(I_READY), 32'h1);
      edge_step();

      // Bypass of same-cycle writeback.
      wb(1, 3, 32'h11);
      cycle();
      issue(1, 3, 0, 0, 0);
      wb(1, 3, 32'hAB);
      cycle();
      chk("bypass_oa", O_A, 32'hAB);
      wb(0, 0, 0);
      cycle();
      chk("after_wb_oa", O_A, 32'hAB);

      // RAW stall until writeback of r5.
      issue(1, 0, 0, 5, 1);
      cycle();
      issue(1, 0, 5, 0, 0);
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("raw_stall", 32'(I_READY), 32'h0);
         edge_step();
      end
      wb(1, 5, 32'h55);
      settle();
      chk("raw_release", 32'(I_READY), 32'h1);
      edge_step();
      chk("raw_ob", O_B, 32'h55);
      wb(0, 0, 0);

      // WAW with set winning over a same-cycle clear.
      issue(1, 0, 0, 7, 1);
      cycle();
      wb(1, 7, 32'h77);
      settle();
      chk("waw_accept", 32'(I_READY), 32'h1);
      edge_step();
      wb(0, 0, 0);
      issue(1, 7, 0, 0, 0);
      settle();
      chk("waw_pend_kept", 32'(I_READY), 32'h0);
      edge_step();
      wb(1, 7, 32'h78);
      cycle();
      wb(0, 0, 0);

      // Backpressure holds the output stage.
      issue(1, 1, 2, 10, 0);
      cycle();
      O_READY = 0;
      issue(1, 4, 4, 11, 1);
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_iready", 32'(I_READY), 32'h0);
         edge_step();
         chk("bp_oa", O_A, 32'h1001);
         chk("bp_ob", O_B, 32'h1002);
         chk("bp_ord", 32'(O_RD), 32'd10);
      end
      O_READY = 1;
      for (int i = 0; i < 3; i++) begin
         issue(1, 5'(4 + 2 * i), 0, 0, 0);
         cycle();
         chk("tput_valid", 32'(O_VALID), 32'h1);
         chk("tput_oa", O_A, 32'h1000 + 4 + 2 * i);
      end

      // Reset during a stall clears the scoreboard.
      issue(1, 0, 0, 9, 1);
      cycle();
      issue(1, 9, 0, 0, 0);
      settle();
      chk("pre_rst_stall", 32'(I_READY), 32'h0);
      edge_step();
      RST = 1;
      cycle();
      RST = 0;
      settle();
      chk("post_rst_ready", 32'(I_READY), 32'h1);
      edge_step();
      chk("post_rst_valid", 32'(O_VALID), 32'h1);
      chk("post_rst_oa", O_A, 32'h1009);

      // Random traffic on a small register window.
      for (int n = 0; n < 1500; n++) begin
         RST = ($urandom_range(0, 199) == 0);
         O_READY = ($urandom_range(0, 3) != 0);
         issue(($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
